// File: rtl/toy_audio_pkg.sv
// toy_audio_pkg: shared types, widths and saturation helper for the audio output stage
package toy_audio_pkg;
  typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} ramp_state_t;
  localparam int RAMP_W = 9;
  localparam int PROD_W = 30;
  function automatic logic signed [15:0] sat16(input logic signed [PROD_W-12:0] y);
    return (y[PROD_W-12:15] == {(PROD_W-26){y[15]}}) ? y[15:0] : {y[PROD_W-12], {15{~y[PROD_W-12]}}};
  endfunction
endpackage

// File: rtl/fs_strobe_gen.sv
// fs_strobe_gen: drift-free fractional divider producing FS_HZ ticks per CLK_HZ cycles
module fs_strobe_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FS_HZ = 48_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  logic [25:0] acc;
  logic [26:0] sum;
  assign sum = {1'b0, acc} + 27'(FS_HZ);
  assign tick = sum >= 27'(CLK_HZ);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else acc <= tick ? 26'(sum - 27'(CLK_HZ)) : sum[25:0];
endmodule

// File: rtl/toy_audio_out.sv
// toy_audio_out: resamples core PCM at FS_HZ with volume, click-free mute ramp and 16-bit saturation
module toy_audio_out
  import toy_audio_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int FS_HZ = 48_000,
  parameter int RAMP_MAX = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] pcm_in,
  input  logic [3:0]         vol,
  input  logic               mute,
  input  logic               clip_clr,
  output logic signed [15:0] pcm_out,
  output logic               sample_stb,
  output logic               clip,
  output logic               muted
);
  localparam logic [RAMP_W-1:0] RMAX = RAMP_W'(RAMP_MAX);
  localparam logic [RAMP_W-1:0] ONE = RAMP_W'(1);
  ramp_state_t state;
  logic tick, v1, v2, sat;
  logic [RAMP_W-1:0] ramp, ramp_r;
  logic signed [15:0] pcm_r;
  logic [3:0] vol_r;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-12:0] y;
  fs_strobe_gen #(.CLK_HZ(CLK_HZ), .FS_HZ(FS_HZ)) u_stb (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign muted = state == MUTED;
  assign y = (PROD_W-11)'(prod >>> 11);
  assign sat = y[PROD_W-12:15] != {(PROD_W-26){y[15]}};
  // direction reversals hold the current level for one tick, so the ramp never jumps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MUTED;
      ramp <= '0;
    end else if (tick)
      case (state)
        MUTED: if (!mute) state <= RAMP_UP;
        RAMP_UP:
          if (mute) state <= (ramp == '0) ? MUTED : RAMP_DOWN;
          else begin
            ramp <= ramp + ONE;
            if (ramp + ONE == RMAX) state <= PLAY;
          end
        PLAY: if (mute) state <= RAMP_DOWN;
        RAMP_DOWN:
          if (!mute) state <= (ramp == RMAX) ? PLAY : RAMP_UP;
          else begin
            ramp <= ramp - ONE;
            if (ramp == ONE) state <= MUTED;
          end
        default: state <= MUTED;
      endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      sample_stb <= 1'b0;
      clip <= 1'b0;
      pcm_out <= '0;
      pcm_r <= '0;
      vol_r <= '0;
      ramp_r <= '0;
      prod <= '0;
    end else begin
      v1 <= tick;
      v2 <= v1;
      sample_stb <= v2;
      if (tick) begin
        pcm_r <= pcm_in;
        vol_r <= vol;
        ramp_r <= ramp;
      end
      if (v1) prod <= PROD_W'(pcm_r) * PROD_W'($signed({1'b0, vol_r})) * PROD_W'($signed({1'b0, ramp_r}));
      if (v2) pcm_out <= sat16(y);
      clip <= (v2 & sat) | (clip & ~clip_clr);
    end
endmodule

// File: tb/tb_toy_audio_out.sv
// tb_toy_audio_out: directed/random stimulus against a level-and-direction model of the fade
module tb_toy_audio_out;
  localparam longint D_CLK = 50_000_000, D_FS = 48_000;
  localparam longint F_CLK = 1000, F_FS = 97;
  localparam int RMAX = 256;
  logic clk = 0, rst_n = 0, mute = 1, clip_clr = 0;
  logic signed [15:0] pcm_in = 0;
  logic [3:0] vol = 8;
  logic signed [15:0] pcm_out, d_pcm;
  logic sample_stb, clip, muted, d_stb, d_clip, d_muted;
  int checks = 0, passed = 0, r = 0, n;
  bit up = 0, pv_sat = 0, clip_m = 0;
  longint cyc = 0, pv_due = -1, p, y;
  int pv_val = 0, out_m = 0;

  toy_audio_out #(.CLK_HZ(int'(F_CLK)), .FS_HZ(int'(F_FS)), .RAMP_MAX(RMAX)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_in(pcm_in), .vol(vol), .mute(mute), .clip_clr(clip_clr),
    .pcm_out(pcm_out), .sample_stb(sample_stb), .clip(clip), .muted(muted));
  toy_audio_out dut_d (
    .clk(clk), .rst_n(rst_n), .pcm_in(pcm_in), .vol(vol), .mute(mute), .clip_clr(clip_clr),
    .pcm_out(d_pcm), .sample_stb(d_stb), .clip(d_clip), .muted(d_muted));

  always #5 clk = ~clk;

  function automatic bit tick_at(longint k, longint c, longint f);
    return k >= 1 && (k * f / c != (k - 1) * f / c);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    cyc = 0; pv_due = -1; r = 0; up = 0; clip_m = 0; out_m = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pcm"}, pcm_out, 0);
    chk({tag, "_stb"}, sample_stb, 0);
    chk({tag, "_clip"}, clip, 0);
    chk({tag, "_muted"}, muted, 1);
    chk({tag, "_d_stb"}, d_stb, 0);
  endtask

  task automatic step();
    bit clr_e;
    @(posedge clk);
    cyc++;
    clr_e = clip_clr;
    if (pv_due == cyc) begin
      out_m = pv_val;
      clip_m = pv_sat | (clip_m & !clr_e);
    end else clip_m = clip_m & !clr_e;
    if (tick_at(cyc, F_CLK, F_FS)) begin
      p = longint'(pcm_in) * longint'(vol) * r;
      y = p >>> 11;
      pv_sat = y > 32767 || y < -32768;
      pv_val = y > 32767 ? 32767 : y < -32768 ? -32768 : int'(y);
      pv_due = cyc + 2;
      if (!mute != up) up = !mute;
      else if (up) r = r < RMAX ? r + 1 : r;
      else r = r > 0 ? r - 1 : 0;
    end
    #1;
    chk("stb", sample_stb, pv_due == cyc);
    chk("pcm_out", pcm_out, out_m);
    chk("clip", clip, clip_m);
    chk("muted", muted, !up && r == 0);
    chk("d_stb", d_stb, cyc >= 3 && tick_at(cyc - 2, D_CLK, D_FS));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    @(negedge clk) rst_n = 1;
    model_reset();
    n = 0;
    while (d_stb !== 1'b1 && n < 1200) begin step(); n++; end
    chk("first_stb_cycle", 32'(cyc), 1044);

    mute = 0; vol = 8; pcm_in = 16384;
    n = 0;
    while (!(up && r == RMAX) && n < 4000) begin step(); n++; end
    chk("fade_in_done", up && r == RMAX, 1);
    repeat (30) step();
    chk("full_pcm", pcm_out, 16384);
    chk("full_muted", muted, 0);
    chk("full_clip", clip, 0);

    pcm_in = 32767;
    repeat (30) step();
    chk("max_unity", pcm_out, 32767);
    chk("max_unity_clip", clip, 0);
    vol = 15;
    repeat (30) step();
    chk("max_gain", pcm_out, 32767);
    chk("max_gain_clip", clip, 1);
    vol = 8;
    repeat (30) step();
    clip_clr = 1; step(); clip_clr = 0;
    repeat (2) step();
    chk("clip_cleared", clip, 0);

    pcm_in = -32768; vol = 15;
    n = 0;
    while (!(pv_due == cyc + 1 && pv_sat) && n < 40) begin step(); n++; end
    clip_clr = 1; step(); clip_clr = 0;
    chk("neg_sat_stb", sample_stb, 1);
    chk("neg_sat_pcm", pcm_out, -32768);
    chk("set_beats_clr", clip, 1);
    clip_clr = 1; step(); clip_clr = 0;

    repeat (400) begin
      pcm_in = 16'($urandom);
      vol = 4'($urandom);
      clip_clr = ($urandom_range(15) == 0);
      step();
    end
    clip_clr = 0; vol = 8; pcm_in = 16384;

    mute = 1;
    n = 0;
    while (!(!up && r == 0) && n < 4000) begin step(); n++; end
    repeat (3) step();
    chk("faded_out", muted, 1);
    mute = 0;
    n = 0;
    while (!(up && r == 100) && n < 2000) begin step(); n++; end
    chk("reach_100", r, 100);
    mute = 1;
    n = 0;
    while (!(!up && r == 50) && n < 1000) begin step(); n++; end
    chk("reach_50", r, 50);
    chk("not_muted_50", muted, 0);
    mute = 0;
    n = 0;
    while (!(up && r == 60) && n < 1000) begin step(); n++; end
    mute = 1;
    n = 0;
    while (!(!up && r == 1) && n < 1000) begin step(); n++; end
    chk("muted_at_1", muted, 0);
    while (!(!up && r == 0) && n < 2000) begin step(); n++; end
    chk("muted_at_0", muted, 1);

    mute = 0;
    n = 0;
    while (!(up && r == 20) && n < 1000) begin step(); n++; end
    mute = 1;
    n = 0;
    while (!(!up && r < 20 && pv_due == cyc + 1) && n < 1000) begin step(); n++; end
    chk("in_ramp_down", !up && r > 0, 1);
    #2 rst_n = 0;
    #1 chk_reset("async_rst");
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset("held_rst");
    @(negedge clk) rst_n = 1;
    repeat (30) step();
    chk("post_rst_muted", muted, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
